// File: rtl/memory_access.sv
// Load/store unit: start -> bus request next cycle; done one cycle after ack, or one cycle after start for rejected accesses.
// Holds all bus outputs stable while waiting on dmem_ack; aborts with err after ACK_TIMEOUT unacknowledged cycles.
module memory_access #(
  parameter int XLEN        = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  input  logic [2:0]      funct3,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [XLEN-1:0] load_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [3:0]      dmem_wstrb,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(ACK_TIMEOUT);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_inc;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_offset;
  logic        lat_load;

  logic        req_bus;
  logic        req_err;
  logic        f3_legal;
  logic        misaligned;
  logic [3:0]  strb_fmt;
  logic [XLEN-1:0] wdata_fmt;
  logic [XLEN-1:0] rdata_fmt;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign wait_cnt_inc = wait_cnt + 8'd1;

  // Classify the request presented in IDLE: bus access, or immediate completion with/without err.
  always_comb begin
    req_bus    = 1'b0;
    req_err    = 1'b0;
    f3_legal   = 1'b0;
    misaligned = 1'b0;
    if (mem_read && mem_write) begin
      req_err = 1'b1;
    end else if (mem_read || mem_write) begin
      if (mem_read)
        f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
      else
        f3_legal = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
      misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                   ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      if (!f3_legal || misaligned)
        req_err = 1'b1;
      else
        req_bus = 1'b1;
    end
  end

  always_comb begin
    strb_fmt  = 4'b1111;
    wdata_fmt = store_data;
    case (funct3[1:0])
      2'b00: begin
        strb_fmt  = 4'b0001 << addr[1:0];
        wdata_fmt = {4{store_data[7:0]}};
      end
      2'b01: begin
        strb_fmt  = 4'b0011 << addr[1:0];
        wdata_fmt = {2{store_data[15:0]}};
      end
      default: begin
        strb_fmt  = 4'b1111;
        wdata_fmt = store_data;
      end
    endcase
  end

  // Load formatting works off the offset/size latched at start, not the live inputs.
  always_comb begin
    rd_byte = dmem_rdata[7:0];
    case (lat_offset)
      2'b00:   rd_byte = dmem_rdata[7:0];
      2'b01:   rd_byte = dmem_rdata[15:8];
      2'b10:   rd_byte = dmem_rdata[23:16];
      default: rd_byte = dmem_rdata[31:24];
    endcase
    rd_half = lat_offset[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (lat_funct3)
      3'b000:  rdata_fmt = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  rdata_fmt = {24'd0, rd_byte};
      3'b001:  rdata_fmt = {{16{rd_half[15]}}, rd_half};
      3'b101:  rdata_fmt = {16'd0, rd_half};
      default: rdata_fmt = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      load_data  <= '0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_wdata <= '0;
      dmem_wstrb <= 4'b0000;
      wait_cnt   <= 8'd0;
      lat_funct3 <= 3'b000;
      lat_offset <= 2'b00;
      lat_load   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (req_bus) begin
              state      <= S_WAIT;
              dmem_req   <= 1'b1;
              dmem_we    <= mem_write;
              dmem_addr  <= {addr[XLEN-1:2], 2'b00};
              dmem_wdata <= wdata_fmt;
              dmem_wstrb <= mem_write ? strb_fmt : 4'b0000;
              lat_funct3 <= funct3;
              lat_offset <= addr[1:0];
              lat_load   <= mem_read;
              wait_cnt   <= 8'd0;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
              err   <= req_err;
            end
          end
        end
        S_WAIT: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (dmem_ack) begin
            state    <= S_DONE;
            done     <= 1'b1;
            err      <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (lat_load)
              load_data <= rdata_fmt;
          end else if (wait_cnt_inc == TIMEOUT_LIM) begin
            state    <= S_DONE;
            done     <= 1'b1;
            err      <= 1'b1;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            wait_cnt <= wait_cnt_inc;
          end else begin
            wait_cnt <= wait_cnt_inc;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access with ACK_TIMEOUT=4; the bench plays the memory side by hand.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [2:0]  funct3;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int n_checks = 0;
  int n_errors = 0;

  memory_access #(.XLEN(32), .ACK_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .addr       (addr),
    .store_data (store_data),
    .funct3     (funct3),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .load_data  (load_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    store_data = d;
    start      = 1'b1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = '0; store_data = '0; funct3 = 3'b000; dmem_rdata = '0; dmem_ack = 1'b0;
    step(); step();

    check_val("rst_busy",  {31'd0, busy}, 32'd0);
    check_val("rst_done",  {31'd0, done}, 32'd0);
    check_val("rst_err",   {31'd0, err}, 32'd0);
    check_val("rst_req",   {31'd0, dmem_req}, 32'd0);
    check_val("rst_we",    {31'd0, dmem_we}, 32'd0);
    check_val("rst_addr",  dmem_addr, 32'd0);
    check_val("rst_wdata", dmem_wdata, 32'd0);
    check_val("rst_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    check_val("rst_ldata", load_data, 32'd0);
    rst = 1'b0;
    step();

    // LB at 0x1003, ack in the first WAIT cycle.
    issue(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'd0);
    step(); idle_inputs();
    check_val("lb_req",   {31'd0, dmem_req}, 32'd1);
    check_val("lb_we",    {31'd0, dmem_we}, 32'd0);
    check_val("lb_addr",  dmem_addr, 32'h0000_1000);
    check_val("lb_wstrb", {28'd0, dmem_wstrb}, 32'd0);
    check_val("lb_busy",  {31'd0, busy}, 32'd1);
    check_val("lb_early_done", {31'd0, done}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_0000;
    step(); dmem_ack = 1'b0;
    check_val("lb_done",  {31'd0, done}, 32'd1);
    check_val("lb_err",   {31'd0, err}, 32'd0);
    check_val("lb_ldata", load_data, 32'hFFFF_FF80);
    check_val("lb_req_drop", {31'd0, dmem_req}, 32'd0);
    step();
    check_val("lb_done_1cyc", {31'd0, done}, 32'd0);
    check_val("lb_idle_busy", {31'd0, busy}, 32'd0);

    // SH at 0x2002, ack held off one cycle; outputs must stay stable.
    issue(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD);
    step(); idle_inputs(); store_data = 32'h5555_5555;
    check_val("sh_wstrb", {28'd0, dmem_wstrb}, 32'h0000_000C);
    check_val("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    check_val("sh_we",    {31'd0, dmem_we}, 32'd1);
    check_val("sh_addr",  dmem_addr, 32'h0000_2000);
    step();
    check_val("sh_req_hold",   {31'd0, dmem_req}, 32'd1);
    check_val("sh_wdata_hold", dmem_wdata, 32'hABCD_ABCD);
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;
    step(); dmem_ack = 1'b0;
    check_val("sh_done",  {31'd0, done}, 32'd1);
    check_val("sh_err",   {31'd0, err}, 32'd0);
    check_val("sh_ldata_kept", load_data, 32'hFFFF_FF80);
    step();

    // SB at 0x5001.
    issue(1'b0, 1'b1, 3'b000, 32'h0000_5001, 32'h1234_5678);
    step(); idle_inputs();
    check_val("sb_wstrb", {28'd0, dmem_wstrb}, 32'h0000_0002);
    check_val("sb_wdata", dmem_wdata, 32'h7878_7878);
    dmem_ack = 1'b1;
    step(); dmem_ack = 1'b0;
    check_val("sb_done", {31'd0, done}, 32'd1);
    step();

    // Misaligned LW: no bus cycle, done with err one cycle after start.
    issue(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0);
    step(); idle_inputs();
    check_val("lw_mis_done", {31'd0, done}, 32'd1);
    check_val("lw_mis_err",  {31'd0, err}, 32'd1);
    check_val("lw_mis_req",  {31'd0, dmem_req}, 32'd0);
    step();
    check_val("lw_mis_req2", {31'd0, dmem_req}, 32'd0);
    check_val("lw_mis_done_1cyc", {31'd0, done}, 32'd0);

    // LHU at 0x4002 with ack withheld: four request cycles, then timeout.
    issue(1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'd0);
    step(); idle_inputs();
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("to_req_c%0d", i), {31'd0, dmem_req}, 32'd1);
      check_val($sformatf("to_nodone_c%0d", i), {31'd0, done}, 32'd0);
      step();
    end
    check_val("to_done",  {31'd0, done}, 32'd1);
    check_val("to_err",   {31'd0, err}, 32'd1);
    check_val("to_req",   {31'd0, dmem_req}, 32'd0);
    check_val("to_ldata", load_data, 32'hFFFF_FF80);
    // Late acks with no request outstanding are ignored.
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step(); step(); dmem_ack = 1'b0;
    check_val("stray_ack_done",  {31'd0, done}, 32'd0);
    check_val("stray_ack_busy",  {31'd0, busy}, 32'd0);
    check_val("stray_ack_ldata", load_data, 32'hFFFF_FF80);

    // LH at 0x6002 acked in the same cycle the timeout would fire.
    issue(1'b1, 1'b0, 3'b001, 32'h0000_6002, 32'd0);
    step(); idle_inputs();
    step(); step(); step();
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_1234;
    step(); dmem_ack = 1'b0;
    check_val("race_done",  {31'd0, done}, 32'd1);
    check_val("race_err",   {31'd0, err}, 32'd0);
    check_val("race_ldata", load_data, 32'hFFFF_8001);
    step();

    // Reset in WAIT, then a late ack; next LW completes normally.
    issue(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'd0);
    step(); idle_inputs();
    check_val("rw_req", {31'd0, dmem_req}, 32'd1);
    rst = 1'b1;
    step(); rst = 1'b0;
    check_val("rw_req_drop", {31'd0, dmem_req}, 32'd0);
    check_val("rw_busy",     {31'd0, busy}, 32'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
    step(); dmem_ack = 1'b0;
    check_val("rw_no_done", {31'd0, done}, 32'd0);
    check_val("rw_busy2",   {31'd0, busy}, 32'd0);
    issue(1'b1, 1'b0, 3'b010, 32'h0000_7004, 32'd0);
    step(); idle_inputs();
    check_val("rw_lw_addr", dmem_addr, 32'h0000_7004);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    step(); dmem_ack = 1'b0;
    check_val("rw_lw_done",  {31'd0, done}, 32'd1);
    check_val("rw_lw_ldata", load_data, 32'hDEAD_BEEF);
    step();

    // Both read and write with start held: done every other cycle, never a bus cycle.
    issue(1'b1, 1'b1, 3'b010, 32'h0000_9000, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      check_val($sformatf("rw_both_done_c%0d", i), {31'd0, done}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check_val($sformatf("rw_both_req_c%0d", i), {31'd0, dmem_req}, 32'd0);
    end
    check_val("rw_both_err", {31'd0, err}, 32'd1);
    idle_inputs();
    step(); step();

    // Legal LW with start held: one access per IDLE sample.
    issue(1'b1, 1'b0, 3'b010, 32'h0000_8000, 32'd0);
    step();
    check_val("held_req1", {31'd0, dmem_req}, 32'd1);
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_0001;
    step(); dmem_ack = 1'b0;
    check_val("held_done", {31'd0, done}, 32'd1);
    step();
    check_val("held_idle_req",  {31'd0, dmem_req}, 32'd0);
    check_val("held_idle_busy", {31'd0, busy}, 32'd0);
    step(); idle_inputs();
    check_val("held_req2", {31'd0, dmem_req}, 32'd1);
    dmem_ack = 1'b1;
    step(); dmem_ack = 1'b0;
    step();

    // Illegal load funct3 and a start with no operation.
    issue(1'b1, 1'b0, 3'b011, 32'h0000_A000, 32'd0);
    step(); idle_inputs();
    check_val("bad_f3_done", {31'd0, done}, 32'd1);
    check_val("bad_f3_err",  {31'd0, err}, 32'd1);
    check_val("bad_f3_req",  {31'd0, dmem_req}, 32'd0);
    step();
    issue(1'b0, 1'b0, 3'b000, 32'h0000_B000, 32'd0);
    step(); idle_inputs();
    check_val("nop_done", {31'd0, done}, 32'd1);
    check_val("nop_err",  {31'd0, err}, 32'd0);
    check_val("nop_req",  {31'd0, dmem_req}, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
